// File: rtl/digit_sequencer_if.sv
// Bus between the result register / bin2dec path and digit_sequencer.
// master drives the reading and loop control; slave is the sequencer.
interface digit_sequencer_if;
    logic [5:0] i_value;
    logic       i_valid;
    logic       i_loop;
    logic [5:0] o_bin;
    logic       o_tens;
    logic       o_ones;
    logic       o_blank;
    logic       o_busy;
    logic       o_frame_done;

    modport master (
        output i_value,
        output i_valid,
        output i_loop,
        input  o_bin,
        input  o_tens,
        input  o_ones,
        input  o_blank,
        input  o_busy,
        input  o_frame_done
    );

    modport slave (
        input  i_value,
        input  i_valid,
        input  i_loop,
        output o_bin,
        output o_tens,
        output o_ones,
        output o_blank,
        output o_busy,
        output o_frame_done
    );
endinterface

// File: rtl/digit_sequencer.sv
// Time-multiplexes a 6-bit reading onto bin2dec: tens digit, gap,
// ones digit, gap; with leading-zero suppression and repeat mode.
module digit_sequencer #(
    parameter int DWELL       = 8,
    parameter int GAP         = 2,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    digit_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, TENS, GAP_T, ONES, GAP_O
    } state_t;

    localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);
    localparam logic [15:0] GAP_M1   = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  bin_q, bin_d;
    logic        pend_q, pend_d;
    logic [5:0]  pval_q, pval_d;
    logic        tens_q, tens_d;
    logic        ones_q, ones_d;
    logic        blank_q, blank_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        start;
    logic [5:0]  start_val;
    logic        frame_end;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            pend_q  <= 1'b0;
            pval_q  <= '0;
            tens_q  <= 1'b0;
            ones_q  <= 1'b0;
            blank_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        pend_d    = pend_q;
        pval_d    = pval_q;
        start     = 1'b0;
        start_val = bus.i_value;
        frame_end = 1'b0;

        unique case (state_q)
            IDLE: begin
                start = bus.i_valid;
            end
            TENS: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (GAP == 0) begin
                    state_d = ONES;
                    cnt_d   = DWELL_M1;
                end else begin
                    state_d = GAP_T;
                    cnt_d   = GAP_M1;
                end
            end
            GAP_T: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = ONES;
                    cnt_d   = DWELL_M1;
                end
            end
            ONES: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (GAP == 0) begin
                    frame_end = 1'b1;
                end else begin
                    state_d = GAP_O;
                    cnt_d   = GAP_M1;
                end
            end
            GAP_O: begin
                if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                else                frame_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Mid-frame writes are parked so o_bin never tears a frame.
        if (bus.i_valid && state_q != IDLE && !frame_end) begin
            pend_d = 1'b1;
            pval_d = bus.i_value;
        end

        if (frame_end) begin
            if (bus.i_valid) begin
                start  = 1'b1;
                pend_d = 1'b0;
            end else if (pend_q) begin
                start     = 1'b1;
                start_val = pval_q;
                pend_d    = 1'b0;
            end else if (bus.i_loop) begin
                start     = 1'b1;
                start_val = bin_q;
            end else begin
                state_d = IDLE;
            end
        end

        if (start) begin
            bin_d = start_val;
            cnt_d = DWELL_M1;
            if (start_val >= 6'd10 || LZ_SUPPRESS == 0) state_d = TENS;
            else                                        state_d = ONES;
        end
    end

    always_comb begin
        tens_d  = (state_d == TENS);
        ones_d  = (state_d == ONES);
        blank_d = !(tens_d || ones_d);
        busy_d  = (state_d != IDLE);
        done_d  = (cnt_d == 16'd0) &&
                  ((state_d == GAP_O) || (GAP == 0 && state_d == ONES));
    end

    assign bus.o_bin        = bin_q;
    assign bus.o_tens       = tens_q;
    assign bus.o_ones       = ones_q;
    assign bus.o_blank      = blank_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench for digit_sequencer at default parameters
// (DWELL=8, GAP=2, LZ_SUPPRESS=1).
module tb_digit_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    digit_sequencer_if bus ();

    digit_sequencer dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"},  32'(bus.o_busy),       0);
        chk({tag, " blank"}, 32'(bus.o_blank),      1);
        chk({tag, " tens"},  32'(bus.o_tens),       0);
        chk({tag, " ones"},  32'(bus.o_ones),       0);
        chk({tag, " done"},  32'(bus.o_frame_done), 0);
    endtask

    // Checks a frame starting at its cycle 1; ends on its last cycle.
    task automatic run_frame(input int v, input bit two);
        int l;
        l = two ? 20 : 10;
        for (int c = 1; c <= l; c++) begin
            bit t;
            bit o;
            t = two && (c <= 8);
            o = two ? (c >= 11 && c <= 18) : (c <= 8);
            chk($sformatf("tens v%0d c%0d", v, c),
                32'(bus.o_tens), 32'(t));
            chk($sformatf("ones v%0d c%0d", v, c),
                32'(bus.o_ones), 32'(o));
            chk($sformatf("blank v%0d c%0d", v, c),
                32'(bus.o_blank), 32'(!(t || o)));
            chk($sformatf("done v%0d c%0d", v, c),
                32'(bus.o_frame_done), 32'(c == l));
            chk($sformatf("busy v%0d c%0d", v, c), 32'(bus.o_busy), 1);
            chk($sformatf("bin v%0d c%0d", v, c), 32'(bus.o_bin), 32'(v));
            if (c < l) step();
        end
    endtask

    task automatic launch(input logic [5:0] v);
        bus.i_value = v;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst         = 1'b1;
        bus.i_value = '0;
        bus.i_valid = 1'b0;
        bus.i_loop  = 1'b0;

        for (int i = 0; i < 4; i++) begin
            bus.i_value = 6'($urandom);
            bus.i_valid = 1'($urandom);
            bus.i_loop  = 1'($urandom);
            step();
        end
        chk_idle("reset");
        chk("reset bin", 32'(bus.o_bin), 0);

        // release and strobe on the same cycle: next edge accepts it
        rst         = 1'b0;
        bus.i_loop  = 1'b0;
        launch(6'd42);
        run_frame(42, 1);
        step();
        chk_idle("after42");

        launch(6'd7);
        run_frame(7, 0);
        step();
        chk_idle("after7");

        launch(6'd0);
        run_frame(0, 0);
        step();
        chk_idle("after0");

        launch(6'd10);
        run_frame(10, 1);
        step();
        chk_idle("after10");

        // mid-frame writes: latest wins, shown only after frame end
        bus.i_value = 6'd42;
        bus.i_valid = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                chk($sformatf("hold bin c%0d", c), 32'(bus.o_bin), 42);
            end
            bus.i_valid = (c == 0 || c == 5 || c == 6);
            bus.i_value = (c == 5) ? 6'd13 : (c == 6) ? 6'd25 : 6'd42;
            step();
        end
        bus.i_valid = 1'b0;
        run_frame(25, 1);
        step();
        chk_idle("after25");

        // strobe on the frame-end cycle bypasses straight into next frame
        launch(6'd42);
        for (int c = 1; c <= 20; c++) begin
            if (c == 20) begin
                chk("bypass done", 32'(bus.o_frame_done), 1);
                bus.i_value = 6'd33;
                bus.i_valid = 1'b1;
            end
            step();
        end
        bus.i_valid = 1'b0;
        run_frame(33, 1);
        step();
        chk_idle("after33");

        // repeat mode
        bus.i_loop = 1'b1;
        launch(6'd63);
        for (int c = 1; c <= 61; c++) begin
            if (c == 50) bus.i_loop = 1'b0;
            if (c <= 60) begin
                chk($sformatf("loop done c%0d", c),
                    32'(bus.o_frame_done), 32'(c % 20 == 0));
                chk($sformatf("loop busy c%0d", c), 32'(bus.o_busy), 1);
                chk($sformatf("loop tens c%0d", c),
                    32'(bus.o_tens), 32'((c - 1) % 20 < 8));
                chk($sformatf("loop bin c%0d", c), 32'(bus.o_bin), 63);
            end else begin
                chk_idle("loop end");
            end
            if (c < 61) step();
        end

        // reset mid-ONES with a pending value
        bus.i_value = 6'd42;
        bus.i_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.i_valid = (c == 0 || c == 5);
            bus.i_value = (c == 5) ? 6'd25 : 6'd42;
            step();
        end
        bus.i_valid = 1'b0;
        chk("pre-reset ones", 32'(bus.o_ones), 1);
        rst = 1'b1;
        #1;
        chk_idle("async reset");
        chk("async reset bin", 32'(bus.o_bin), 0);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            chk($sformatf("no replay busy c%0d", c), 32'(bus.o_busy), 0);
        end
        chk("no replay bin", 32'(bus.o_bin), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
